// File: rtl/lsu_stb_ctlstate.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_stb_ctlstate
//  Purpose  : Store-buffer control-state array. Holds per-entry M-stage store
//             control fields (set index, request type, RMO) and a per-entry
//             EMPTY/VALID/ISSUED lifecycle with issue/ack/nack/flush.
//             Provides occupancy, a registered indexed read port and a
//             sticky protocol-error flag.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_stb_ctlstate #(
  parameter int NENT  = 8,
  parameter int SI_W  = 2,
  parameter int RT_W  = 2,
  parameter int IDX_W = 3
) (
  input  logic                 rclk,
  input  logic                 arst_l,
  input  logic [NENT-1:0]      stb_wr_en_m,
  input  logic [SI_W-1:0]      lsu_stb_va_m,
  input  logic [RT_W-1:0]      lsu_st_rq_type_m,
  input  logic                 lsu_st_rmo_m,
  input  logic                 stb_issue_vld,
  input  logic [IDX_W-1:0]     stb_issue_idx,
  input  logic                 stb_ack_vld,
  input  logic [IDX_W-1:0]     stb_ack_idx,
  input  logic                 stb_nack_vld,
  input  logic [NENT-1:0]      stb_flush,
  input  logic [IDX_W-1:0]     stb_rd_idx,
  output logic [NENT-1:0]      stb_state_vld,
  output logic [NENT-1:0]      stb_state_iss,
  output logic [NENT*SI_W-1:0] stb_state_si,
  output logic [NENT*RT_W-1:0] stb_state_rtype,
  output logic [NENT-1:0]      stb_state_rmo,
  output logic [SI_W-1:0]      stb_rd_si,
  output logic [RT_W-1:0]      stb_rd_rtype,
  output logic                 stb_rd_rmo,
  output logic [IDX_W:0]       stb_cnt,
  output logic                 stb_full,
  output logic                 stb_empty,
  output logic                 stb_err
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_VALID  = 2'b01,
    ST_ISSUED = 2'b10
  } state_t;

  localparam logic [IDX_W:0] c_nent = (IDX_W+1)'(NENT);

  // Per-entry payload views for the read mux
  logic [SI_W-1:0] w_si [NENT];
  logic [RT_W-1:0] w_rt [NENT];
  logic [NENT-1:0] w_ent_err;

  // Array-wide protocol violations not tied to a single entry
  logic w_multi_wr;
  logic w_iss_oor;
  logic w_ack_oor;
  logic w_rd_oor;
  logic r_err_glob;

  assign w_multi_wr = |(stb_wr_en_m & (stb_wr_en_m - {{(NENT-1){1'b0}}, 1'b1}));
  assign w_iss_oor  = stb_issue_vld && ({1'b0, stb_issue_idx} >= c_nent);
  assign w_ack_oor  = (stb_ack_vld || stb_nack_vld) && ({1'b0, stb_ack_idx} >= c_nent);
  assign w_rd_oor   = ({1'b0, stb_rd_idx} >= c_nent);

  for (genvar gi = 0; gi < NENT; gi++) begin : g_ent
    localparam logic [IDX_W-1:0] c_me = IDX_W'(gi);

    state_t          r_st;
    logic            r_eerr;
    logic [SI_W-1:0] r_si;
    logic [RT_W-1:0] r_rt;
    logic            r_rmo;
    logic            w_wr;
    logic            w_iss;
    logic            w_ack;
    logic            w_nack;
    logic            w_fl;

    assign w_wr   = stb_wr_en_m[gi];
    assign w_iss  = stb_issue_vld && (stb_issue_idx == c_me);
    assign w_ack  = stb_ack_vld   && (stb_ack_idx   == c_me);
    assign w_nack = stb_nack_vld  && (stb_ack_idx   == c_me);
    assign w_fl   = stb_flush[gi];

    // Entry lifecycle FSM with its own sticky violation flag
    always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
        r_st   <= ST_EMPTY;
        r_eerr <= 1'b0;
      end else begin
        case (r_st)
          ST_EMPTY: begin
            if (w_wr) r_st <= ST_VALID;
            if (w_iss || w_ack || w_nack) r_eerr <= 1'b1;
          end
          ST_VALID: begin
            // An overwrite keeps the entry VALID; a flush beats an issue.
            if (w_wr) begin
              r_eerr <= 1'b1;
            end else if (w_fl) begin
              r_st <= ST_EMPTY;
              if (w_iss) r_eerr <= 1'b1;
            end else if (w_iss) begin
              r_st <= ST_ISSUED;
            end
            if (w_ack || w_nack) r_eerr <= 1'b1;
          end
          ST_ISSUED: begin
            // Flush is ignored here; only ack or nack can retire the entry.
            if (w_nack) begin
              r_st <= ST_VALID;
              if (w_ack || w_wr) r_eerr <= 1'b1;
            end else if (w_ack) begin
              r_st <= w_wr ? ST_VALID : ST_EMPTY;
            end else if (w_wr) begin
              r_eerr <= 1'b1;
            end
            if (w_iss) r_eerr <= 1'b1;
          end
          default: r_st <= ST_EMPTY;
        endcase
      end
    end

    // Payload capture on the entry write enable
    always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
        r_si  <= '0;
        r_rt  <= '0;
        r_rmo <= 1'b0;
      end else if (w_wr) begin
        r_si  <= lsu_stb_va_m;
        r_rt  <= lsu_st_rq_type_m;
        r_rmo <= lsu_st_rmo_m;
      end
    end

    assign stb_state_vld[gi]                 = (r_st != ST_EMPTY);
    assign stb_state_iss[gi]                 = (r_st == ST_ISSUED);
    assign stb_state_si[gi*SI_W +: SI_W]     = r_si;
    assign stb_state_rtype[gi*RT_W +: RT_W]  = r_rt;
    assign stb_state_rmo[gi]                 = r_rmo;
    assign w_si[gi]                          = r_si;
    assign w_rt[gi]                          = r_rt;
    assign w_ent_err[gi]                     = r_eerr;
  end

  // Sticky record of array-wide violations
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_err_glob <= 1'b0;
    end else if (w_multi_wr || w_iss_oor || w_ack_oor || w_rd_oor) begin
      r_err_glob <= 1'b1;
    end
  end

  logic [SI_W-1:0] r_rd_si;
  logic [RT_W-1:0] r_rd_rt;
  logic            r_rd_rmo;

  // Read port returns pre-write payload of the sampled index
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_rd_si  <= '0;
      r_rd_rt  <= '0;
      r_rd_rmo <= 1'b0;
    end else if (w_rd_oor) begin
      r_rd_si  <= '0;
      r_rd_rt  <= '0;
      r_rd_rmo <= 1'b0;
    end else begin
      r_rd_si  <= w_si[stb_rd_idx];
      r_rd_rt  <= w_rt[stb_rd_idx];
      r_rd_rmo <= stb_state_rmo[stb_rd_idx];
    end
  end

  assign stb_rd_si    = r_rd_si;
  assign stb_rd_rtype = r_rd_rt;
  assign stb_rd_rmo   = r_rd_rmo;

  logic [IDX_W:0] w_cnt;

  // Occupancy is a straight population count of non-EMPTY entries
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < NENT; k++) begin
      w_cnt = w_cnt + {{IDX_W{1'b0}}, stb_state_vld[k]};
    end
  end

  assign stb_cnt   = w_cnt;
  assign stb_full  = (w_cnt == c_nent);
  assign stb_empty = (w_cnt == '0);
  assign stb_err   = r_err_glob | (|w_ent_err);

endmodule
`default_nettype wire
